// File: rtl/aesha_pkg.sv
// Shared types and constants for the AESHA host front end: FSM states,
// host address map, and per-mode result word counts.
package aesha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DRAIN,
        ST_ERR
    } state_e;

    localparam logic [4:0] KEY_BASE  = 5'd0;
    localparam logic [4:0] DATA_BASE = 5'd4;
    localparam logic [4:0] LAST_ADDR = 5'd19;

    localparam int AES_WORDS    = 4;
    localparam int KECCAK_WORDS = 16;

    localparam logic MODE_AES = 1'b1;

    localparam int KEY_W    = 128;
    localparam int DATA_W   = 512;
    localparam int RESULT_W = 512;

    // Number of result words streamed back for the latched mode.
    function automatic logic [4:0] result_words(input logic mode);
        return (mode == MODE_AES) ? 5'(AES_WORDS) : 5'(KECCAK_WORDS);
    endfunction

endpackage

// File: rtl/aesha_if.sv
// Host-side bundle of the AESHA front end: word write port, launch controls,
// result read port and status. master = host, slave = aesha_host_if.
interface aesha_if;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        i_start;
    logic        i_mode;
    logic        i_enc_or_dec;
    logic        o_rd_valid;
    logic        i_rd_ready;
    logic [31:0] o_rd_data;
    logic        o_rd_last;
    logic        o_busy;
    logic        o_error;

    modport master (
        output i_wr_valid, i_wr_addr, i_wr_data, i_start, i_mode, i_enc_or_dec, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_busy, o_error
    );

    modport slave (
        input  i_wr_valid, i_wr_addr, i_wr_data, i_start, i_mode, i_enc_or_dec, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_busy, o_error
    );
endinterface

// File: rtl/aesha_result_ser.sv
// Result capture register and valid/ready word serializer: a load snapshots
// the core result, then words 0..count-1 stream out, one per handshake.
module aesha_result_ser #(
    parameter int WORD_W = 32,
    parameter int RES_W  = 512
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [4:0]        i_word_cnt,
    input  logic [RES_W-1:0]  i_result,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_data,
    output logic              o_last,
    output logic              o_done
);

    logic [RES_W-1:0] result_q, result_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       last_idx_q, last_idx_d;
    logic             valid_q, valid_d;
    logic             fire;
    logic             at_last;

    assign fire    = valid_q && i_ready;
    assign at_last = valid_q && (idx_q == last_idx_q);

    always_comb begin
        result_d   = result_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        valid_d    = valid_q;
        if (i_load) begin
            result_d   = i_result;
            idx_d      = 4'd0;
            last_idx_d = 4'(i_word_cnt - 5'd1);
            valid_d    = 1'b1;
        end else if (fire) begin
            // Counter parks at 0 after the final word so the next load starts clean.
            idx_d   = at_last ? 4'd0 : idx_q + 4'd1;
            valid_d = !at_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            result_q   <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            result_q   <= result_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            valid_q    <= valid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = result_q[idx_q*WORD_W +: WORD_W];
    assign o_last  = at_last;
    assign o_done  = fire && at_last;

endmodule

// File: rtl/aesha_host_if.sv
// AESHA host front end: buffers key/data words, launches the core by releasing
// its reset, captures the result and streams it back. AESHA_HOST_TIMEOUT_EN adds a launch watchdog.
module aesha_host_if
    import aesha_pkg::*;
#(
    parameter int WORD_W = 32
`ifdef AESHA_HOST_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic                i_clk,
    input  logic                i_reset,
    aesha_if.slave              host,
    output logic                o_core_rst_n,
    output logic                o_aes_or_keccak,
    output logic                o_enc_or_dec,
    output logic [KEY_W-1:0]    o_key,
    output logic [DATA_W-1:0]   o_data,
    input  logic                i_core_busy,
    input  logic                i_core_done,
    input  logic [RESULT_W-1:0] i_result
);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic                dir_q, dir_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                busy_q, busy_d;
    logic                wr_ready_q, wr_ready_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_fire;
    logic [3:0]          data_idx;
    logic                ser_load;
    logic                ser_done;

`ifdef AESHA_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                error_q, error_d;
`endif

    // wr_ready_q is only high in IDLE, so buffers cannot move under a running core.
    assign wr_fire  = host.i_wr_valid && wr_ready_q;
    assign data_idx = 4'(host.i_wr_addr - DATA_BASE);

    always_comb begin
        key_d  = key_q;
        data_d = data_q;
        if (wr_fire) begin
            if (host.i_wr_addr < DATA_BASE) begin
                key_d[2'(host.i_wr_addr - KEY_BASE)*32 +: 32] = host.i_wr_data;
            end else if (host.i_wr_addr <= LAST_ADDR) begin
                data_d[data_idx*32 +: 32] = host.i_wr_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        ser_load = 1'b0;
`ifdef AESHA_HOST_TIMEOUT_EN
        cnt_d    = cnt_q;
        error_d  = error_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef AESHA_HOST_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (host.i_start) begin
                    state_d = ST_LAUNCH;
                    mode_d  = host.i_mode;
                    dir_d   = host.i_enc_or_dec;
                end
            end
            ST_LAUNCH, ST_WAIT: begin
                if (state_q == ST_LAUNCH && i_core_busy) begin
                    state_d = ST_WAIT;
                end
                if (state_q == ST_WAIT && i_core_done) begin
                    state_d  = ST_DRAIN;
                    ser_load = 1'b1;
                end
`ifdef AESHA_HOST_TIMEOUT_EN
                // A completion landing on the expiry cycle still wins.
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_W'(TIMEOUT_CYC) && !ser_load) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef AESHA_HOST_TIMEOUT_EN
            ST_ERR: begin
                if (host.i_start) begin
                    state_d = ST_IDLE;
                    error_d = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        core_rst_n_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
        busy_d       = (state_d != ST_IDLE);
        wr_ready_d   = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            dir_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            wr_ready_q   <= 1'b1;
            key_q        <= '0;
            data_q       <= '0;
`ifdef AESHA_HOST_TIMEOUT_EN
            cnt_q        <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            wr_ready_q   <= wr_ready_d;
            key_q        <= key_d;
            data_q       <= data_d;
`ifdef AESHA_HOST_TIMEOUT_EN
            cnt_q        <= cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    aesha_result_ser #(
        .WORD_W (WORD_W),
        .RES_W  (RESULT_W)
    ) u_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_word_cnt (result_words(mode_q)),
        .i_result   (i_result),
        .o_valid    (host.o_rd_valid),
        .i_ready    (host.i_rd_ready),
        .o_data     (host.o_rd_data),
        .o_last     (host.o_rd_last),
        .o_done     (ser_done)
    );

    assign host.o_wr_ready = wr_ready_q;
    assign host.o_busy     = busy_q;
`ifdef AESHA_HOST_TIMEOUT_EN
    assign host.o_error    = error_q;
`else
    assign host.o_error    = 1'b0;
`endif
    assign o_core_rst_n    = core_rst_n_q;
    assign o_aes_or_keccak = mode_q;
    assign o_enc_or_dec    = dir_q;
    assign o_key           = key_q;
    assign o_data          = data_q;

endmodule

// File: tb/tb_aesha_host_if.sv
// Directed bench for aesha_host_if: key/data writes, AES and Keccak runs,
// backpressure, dropped writes, mid-run reset and (if enabled) the watchdog.
module tb_aesha_host_if;
    import aesha_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         core_rst_n;
    logic         aes_or_keccak;
    logic         enc_or_dec;
    logic [127:0] key;
    logic [511:0] data;
    logic         core_busy;
    logic         core_done;
    logic [511:0] result;

    int total = 0;
    int bad   = 0;

    aesha_if hif();

    aesha_host_if #(
        .WORD_W (32)
`ifdef AESHA_HOST_TIMEOUT_EN
        , .TIMEOUT_CYC (16)
`endif
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .host            (hif),
        .o_core_rst_n    (core_rst_n),
        .o_aes_or_keccak (aes_or_keccak),
        .o_enc_or_dec    (enc_or_dec),
        .o_key           (key),
        .o_data          (data),
        .i_core_busy     (core_busy),
        .i_core_done     (core_done),
        .i_result        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wdata);
        hif.i_wr_valid = 1'b1;
        hif.i_wr_addr  = addr;
        hif.i_wr_data  = wdata;
        tick();
        hif.i_wr_valid = 1'b0;
        $display("wr addr=%0d data=%h", addr, wdata);
    endtask

    task automatic start_op(input logic mode, input logic dir);
        hif.i_start      = 1'b1;
        hif.i_mode       = mode;
        hif.i_enc_or_dec = dir;
        tick();
        hif.i_start = 1'b0;
        $display("start mode=%0d dir=%0d", mode, dir);
    endtask

    // LAUNCH for two cycles, core raises busy, then one done pulse with res.
    task automatic run_core(input logic [511:0] res);
        tick();
        tick();
        core_busy = 1'b1;
        tick();
        chk("wait_rd_valid", hif.o_rd_valid, 1'b0);
        chk("wait_core_rst_n", core_rst_n, 1'b1);
        core_done = 1'b1;
        result    = res;
        tick();
        core_done = 1'b0;
        core_busy = 1'b0;
        result    = '0;
        chk("cap_core_rst_n", core_rst_n, 1'b0);
        chk("cap_rd_valid", hif.o_rd_valid, 1'b1);
    endtask

    task automatic drain(input int nwords, input logic [511:0] res, input bit toggle);
        int  idx;
        bit  rdy;
        idx = 0;
        for (int c = 0; c < 80 && idx < nwords; c++) begin
            rdy = toggle ? (c % 2 == 1) : 1'b1;
            hif.i_rd_ready = rdy;
            chk("rd_valid", hif.o_rd_valid, 1'b1);
            chk("rd_data", hif.o_rd_data, res[idx*32 +: 32]);
            chk("rd_last", hif.o_rd_last, (idx == nwords - 1));
            tick();
            if (rdy) begin
                $display("rd word %0d data=%h", idx, res[idx*32 +: 32]);
                idx++;
            end
        end
        hif.i_rd_ready = 1'b0;
        chk("word_count", idx, nwords);
        chk("end_busy", hif.o_busy, 1'b0);
        chk("end_wr_ready", hif.o_wr_ready, 1'b1);
        chk("end_rd_valid", hif.o_rd_valid, 1'b0);
    endtask

    logic [511:0] inc_bytes;
    logic [511:0] aes_res;
    logic [511:0] exp_data;
    logic [127:0] exp_key;

    initial begin
        rst_n            = 1'b0;
        hif.i_wr_valid   = 1'b0;
        hif.i_wr_addr    = '0;
        hif.i_wr_data    = '0;
        hif.i_start      = 1'b0;
        hif.i_mode       = 1'b0;
        hif.i_enc_or_dec = 1'b0;
        hif.i_rd_ready   = 1'b0;
        core_busy        = 1'b0;
        core_done        = 1'b0;
        result           = '0;
        for (int i = 0; i < 64; i++) inc_bytes[i*8 +: 8] = 8'(i);
        aes_res = inc_bytes ^ {16{32'hDEADBEEF}};
        exp_key = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

        #12;
        chk("rst_wr_ready", hif.o_wr_ready, 1'b1);
        chk("rst_core_rst_n", core_rst_n, 1'b0);
        chk("rst_busy", hif.o_busy, 1'b0);
        chk("rst_rd_valid", hif.o_rd_valid, 1'b0);
        chk("rst_rd_data", hif.o_rd_data, 32'h0);
        chk("rst_rd_last", hif.o_rd_last, 1'b0);
        chk("rst_error", hif.o_error, 1'b0);
        chk("rst_mode", aes_or_keccak, 1'b0);
        chk("rst_key", key, 128'h0);
        chk("rst_data", data, 512'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Key load; the last key word shares its cycle with the AES launch.
        wr(5'd0, 32'h03020100);
        wr(5'd1, 32'h07060504);
        wr(5'd2, 32'h0B0A0908);
        hif.i_wr_valid = 1'b1;
        hif.i_wr_addr  = 5'd3;
        hif.i_wr_data  = 32'h0F0E0D0C;
        chk("pre_launch_core_rst_n", core_rst_n, 1'b0);
        start_op(1'b1, 1'b1);
        hif.i_wr_valid = 1'b0;
        chk("key", key, exp_key);
        chk("launch_core_rst_n", core_rst_n, 1'b1);
        chk("launch_busy", hif.o_busy, 1'b1);
        chk("launch_wr_ready", hif.o_wr_ready, 1'b0);
        chk("launch_mode", aes_or_keccak, 1'b1);
        chk("launch_dir", enc_or_dec, 1'b1);

        // AES with backpressure: ready low on every even cycle.
        run_core(aes_res);
        chk("aes_word0", hif.o_rd_data, 32'h03020100 ^ 32'hDEADBEEF);
        drain(AES_WORDS, aes_res, 1'b1);

        // Data writes, an out-of-range write, then Keccak with a blocked write in WAIT.
        wr(5'd4, 32'h11111111);
        wr(5'd19, 32'h22222222);
        wr(5'd25, 32'hBAD0BAD0);
        exp_data = {32'h22222222, 448'h0, 32'h11111111};
        chk("data_after_writes", data, exp_data);
        chk("key_after_writes", key, exp_key);
        start_op(1'b0, 1'b1);
        chk("keccak_mode", aes_or_keccak, 1'b0);
        tick();
        tick();
        core_busy = 1'b1;
        tick();
        hif.i_wr_valid = 1'b1;
        hif.i_wr_addr  = 5'd5;
        hif.i_wr_data  = 32'hFFFFFFFF;
        chk("wait_wr_ready", hif.o_wr_ready, 1'b0);
        tick();
        hif.i_wr_valid = 1'b0;
        chk("data_after_wait_write", data, exp_data);
        chk("key_after_wait_write", key, exp_key);
        core_done = 1'b1;
        result    = inc_bytes;
        tick();
        core_done = 1'b0;
        core_busy = 1'b0;
        result    = '0;
        chk("keccak_word0", hif.o_rd_data, 32'h03020100);
        drain(KECCAK_WORDS, inc_bytes, 1'b0);

        // Asynchronous reset in the middle of WAIT, then a normal AES run.
        start_op(1'b1, 1'b0);
        tick();
        tick();
        core_busy = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_core_rst_n", core_rst_n, 1'b0);
        chk("mid_rst_busy", hif.o_busy, 1'b0);
        chk("mid_rst_wr_ready", hif.o_wr_ready, 1'b1);
        chk("mid_rst_mode", aes_or_keccak, 1'b0);
        chk("mid_rst_key", key, 128'h0);
        chk("mid_rst_data", data, 512'h0);
        core_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_op(1'b1, 1'b0);
        chk("relaunch_core_rst_n", core_rst_n, 1'b1);
        chk("relaunch_busy", hif.o_busy, 1'b1);
        run_core(~inc_bytes);
        drain(AES_WORDS, ~inc_bytes, 1'b0);

`ifdef AESHA_HOST_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            start_op(1'b1, 1'b0);
            for (int c = 1; c <= 40; c++) begin
                tick();
                cyc = c;
                if (hif.o_error) break;
            end
            chk("timeout_cycles", cyc, 16);
            chk("timeout_error", hif.o_error, 1'b1);
            chk("timeout_core_rst_n", core_rst_n, 1'b0);
            chk("timeout_rd_valid", hif.o_rd_valid, 1'b0);
            start_op(1'b1, 1'b0);
            chk("err_clear_error", hif.o_error, 1'b0);
            chk("err_clear_busy", hif.o_busy, 1'b0);
            chk("err_clear_core_rst_n", core_rst_n, 1'b0);
            chk("err_clear_wr_ready", hif.o_wr_ready, 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
